// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the push-button conditioner:
//   - btn_state_e : debounce FSM states
//   - DEFAULT_DEBOUNCE_CYCLES   : 10 ms at the 128 MHz fabric clock
//   - DEFAULT_LONG_PRESS_CYCLES : 1 s at the 128 MHz fabric clock
// -----------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 32'd1_280_000;
  localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 32'd128_000_000;

endpackage : button_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for asynchronous input pins.
// Parameters:
//   WIDTH     : number of independent bits synchronised
//   RESET_VAL : value loaded into both flop stages on reset
// Ports:
//   clk_i : destination clock
//   rst_i : synchronous active-high reset
//   d_i   : asynchronous input
//   q_o   : synchronised output (two destination-clock cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Debounced push-button conditioner: synchronises the raw pin, filters contact
// bounce with a stability counter and produces a clean level plus one-cycle
// press / release / long-press pulses. All outputs are registered.
// Parameters:
//   DEBOUNCE_CYCLES   : stable cycles needed to accept a new level (>= 2)
//   LONG_PRESS_CYCLES : cycles held before long_press_pulse (> DEBOUNCE_CYCLES)
//   ACTIVE_LOW        : 1 = pin reads 0 when pressed
// Ports:
//   clk_128M         : 128 MHz clock, sole clock domain
//   rst              : synchronous active-high reset
//   btn_in           : raw asynchronous button pin
//   btn_level        : debounced state, 1 = pressed
//   press_pulse      : one-cycle pulse on accepted press
//   release_pulse    : one-cycle pulse on accepted release
//   long_press_pulse : one-cycle pulse once per press after the hold time
// Build option:
//   BUTTON_DEBOUNCE_LONG_PRESS_EN : when defined, the hold counter and
//   long_press_pulse logic are built; otherwise long_press_pulse is tied 0.
// -----------------------------------------------------------------------------
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic clk_128M,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int unsigned   DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_cfg
    $error("button_debounce: need DEBOUNCE_CYCLES >= 2 and LONG_PRESS_CYCLES > DEBOUNCE_CYCLES");
  end

  // Polarity is normalised before the synchroniser (a constant XOR is a plain
  // inverter or wire), so the flops reset to 0 = released for either polarity.
  logic btn_sync;

  sync_2ff #(
    .WIDTH    (1),
    .RESET_VAL(1'b0)
  ) u_sync (
    .clk_i(clk_128M),
    .rst_i(rst),
    .d_i  (btn_in ^ ACTIVE_LOW),
    .q_o  (btn_sync)
  );

  btn_state_e      state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  // State register
  always_ff @(posedge clk_128M) begin
    if (rst) begin
      state_q   <= RELEASED;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state logic. The counter is cleared on entry to a pending state, so
  // the entry cycle plus DEBOUNCE_CYCLES further matching samples are needed.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    unique case (state_q)
      RELEASED: begin
        if (btn_sync) begin
          state_d  = PRESS_PEND;
          db_cnt_d = '0;
        end
      end
      PRESS_PEND: begin
        if (!btn_sync)               state_d  = RELEASED;
        else if (db_cnt_q == DB_LAST) state_d = PRESSED;
        else                          db_cnt_d = db_cnt_q + 1'b1;
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_d  = RELEASE_PEND;
          db_cnt_d = '0;
        end
      end
      RELEASE_PEND: begin
        if (btn_sync)                 state_d  = PRESSED;
        else if (db_cnt_q == DB_LAST) state_d  = RELEASED;
        else                          db_cnt_d = db_cnt_q + 1'b1;
      end
      default: state_d = RELEASED;
    endcase
  end

  // Output logic: pulses only on the accepting transitions, so a bounce back
  // from a pending state never produces a pulse.
  always_comb begin
    press_d   = (state_q == PRESS_PEND)   && (state_d == PRESSED);
    release_d = (state_q == RELEASE_PEND) && (state_d == RELEASED);
    level_d   = (state_d == PRESSED) || (state_d == RELEASE_PEND);
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned       HOLD_W    = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_flag_q, long_flag_d;
  logic              long_q, long_d;

  // The hold counter keeps running through a rejected release bounce. The
  // fire test uses >= so a threshold crossed while in RELEASE_PEND still
  // fires on return to PRESSED; the sticky flag limits it to once per press.
  always_comb begin
    hold_d      = hold_q;
    long_flag_d = long_flag_q;
    long_d      = (state_q == PRESSED) && !long_flag_q && (hold_q >= HOLD_FIRE);
    if (press_d) begin
      hold_d      = '0;
      long_flag_d = 1'b0;
    end else begin
      if ((state_q == PRESSED || state_q == RELEASE_PEND) && hold_q != HOLD_MAX)
        hold_d = hold_q + 1'b1;
      if (long_d)
        long_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk_128M) begin
    if (rst) begin
      hold_q      <= '0;
      long_flag_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      long_flag_q <= long_flag_d;
      long_q      <= long_d;
    end
  end

  assign long_press_pulse = long_q;
`else
  assign long_press_pulse = 1'b0;
`endif

endmodule : button_debounce

// File: doc/button_debounce.md
# button_debounce

Debounced push-button input conditioner on the 128 MHz fabric clock; the input-side counterpart to the LED blink/indicator outputs. Synchronises a raw asynchronous button pin, filters contact bounce with a stability counter, and presents a clean level plus single-cycle press, release and long-press event pulses to downstream control logic.

## Interface
- DEBOUNCE_CYCLES, 1_280_000, consecutive stable cycles required to accept a new level (10 ms at 128 MHz); minimum 2.
- LONG_PRESS_CYCLES, 128_000_000, cycles held in PRESSED before long_press fires (1 s); must exceed DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
- clk_128M  input  1  128 MHz clock; sole clock domain.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous button pin.
- btn_level  output  1  debounced state, 1 = pressed.
- press_pulse  output  1  one-cycle pulse on accepted press.
- release_pulse  output  1  one-cycle pulse on accepted release.
- long_press_pulse  output  1  one-cycle pulse once per press after LONG_PRESS_CYCLES held.

## Operation
- Two-flop synchroniser on btn_in, then polarity normalisation per ACTIVE_LOW → internal btn_sync (1 = pressed).
- FSM states: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
- RELEASED: btn_sync=1 → PRESS_PEND, debounce counter cleared to 0.
- PRESS_PEND: btn_sync=0 → RELEASED (bounce rejected, no pulse); counter reaches DEBOUNCE_CYCLES-1 with btn_sync=1 → PRESSED, assert press_pulse, btn_level←1, hold counter cleared.
- PRESSED: btn_sync=0 → RELEASE_PEND, debounce counter cleared; hold counter increments each cycle, saturates; equals LONG_PRESS_CYCLES-1 → long_press_pulse once (sticky flag blocks repeat until next press).
- RELEASE_PEND: btn_sync=1 → PRESSED (bounce rejected; hold counter keeps running, no pulses); counter reaches DEBOUNCE_CYCLES-1 with btn_sync=0 → RELEASED, release_pulse, btn_level←0.
- Counter widths: $clog2(DEBOUNCE_CYCLES) and $clog2(LONG_PRESS_CYCLES+1); no wrap — hold counter saturates.
- press_pulse, release_pulse, long_press_pulse mutually exclusive in any cycle by construction.

## Timing
- Reset: state RELEASED, all counters 0, long-press flag 0, synchroniser flops 0 (normalised released), btn_level=0, all pulses 0. Outputs registered.
- Reset mid-press: returns to RELEASED with no release_pulse; a still-held button re-debounces and produces a fresh press_pulse.
- Clean edge on btn_in at cycle 0 → btn_level changes and press/release_pulse high in cycle 2 + DEBOUNCE_CYCLES; pulse width exactly 1 cycle.
- long_press_pulse fires LONG_PRESS_CYCLES cycles after press_pulse cycle.
- Bounce shorter than DEBOUNCE_CYCLES in either pending state produces no output change; debounce restarts from 0 on next qualifying edge.
- Button held indefinitely: single press_pulse, single long_press_pulse, btn_level stays 1.

## Configuration
- BUTTON_DEBOUNCE_LONG_PRESS_EN defined: hold counter, sticky flag and long_press_pulse logic present as above.
- Undefined: hold counter and flag removed; long_press_pulse tied 0; LONG_PRESS_CYCLES ignored; all other behaviour identical.

## Structure
- Shared package button_pkg: FSM state enum (RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND), default cycle constants for 128 MHz (10 ms, 1 s).
- One sub-module: sync_2ff (generic two-flop synchroniser, reusable for other async pins).

## Test plan (DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32, ACTIVE_LOW=1)
- Reset asserted 4 cycles with btn_in=0 → all outputs 0 during and after reset; no spurious press.
- btn_in 1→0 clean at cycle 0 → press_pulse and btn_level=1 at cycle 10; pulse 1 cycle wide.
- Press with 3-cycle bounces (0,1,0,1,0 held) → single press_pulse 10 cycles after final stable edge; no release_pulse.
- Hold low 60 cycles → long_press_pulse once, 32 cycles after press_pulse; none afterwards; release → release_pulse 10 cycles after edge.
- Held press, rst pulsed 1 cycle → btn_level=0, no release_pulse; press_pulse re-fires 10 cycles after rst deasserts.
- Macro undefined, hold 60 cycles → long_press_pulse stays 0; press/release timing unchanged.
